// File: rtl/simon_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : simon_key_schedule
// Brief    : Simon round-key generator with valid/ready output stream.
//            Optional round-key store enabled by SIMON_KEY_STORE_EN.
// Revision : 1.0
// ============================================================================
module simon_key_schedule #(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 32,
    parameter int Z_SEQ     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
`ifdef SIMON_KEY_STORE_EN
    input  logic [$clog2(ROUNDS)-1:0]     rd_addr,
    output logic [WORD_W-1:0]             rd_data,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          rk_valid,
    input  logic                          rk_ready,
    output logic [WORD_W-1:0]             rk_data,
    output logic [$clog2(ROUNDS)-1:0]     rk_idx
);

    localparam int IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    // Leftmost character of each sequence is element 0, i.e. bit 61 here.
    localparam logic [61:0] Z_CONST =
        (Z_SEQ == 0) ? 62'b11111010001001010110000111001101111101000100101011000011100110 :
        (Z_SEQ == 1) ? 62'b10001110111110010011000010110101000111011111001001100001011010 :
        (Z_SEQ == 2) ? 62'b10101111011100000011010010011000101000010001111110010110110011 :
        (Z_SEQ == 3) ? 62'b11011011101011000110010111100000010010001010011100110100001111 :
                       62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [KEY_WORDS-1:0][WORD_W-1:0]   win_q;
    logic [KEY_WORDS-1:0][WORD_W-1:0]   w_win_shift;
    logic [WORD_W-1:0]                  rk_data_q;
    logic [IDX_W-1:0]                   rk_idx_q;
    logic [5:0]                         z_q;
    logic                               w_xfer;
    logic                               w_zbit;
    logic [WORD_W-1:0]                  w_ror3, w_mix, w_tmp, w_new;

    // win_q[0] is the oldest word k[i-m]; win_q[KEY_WORDS-1] is k[i-1].
    assign w_ror3 = {win_q[KEY_WORDS-1][2:0], win_q[KEY_WORDS-1][WORD_W-1:3]};

    generate
        if (KEY_WORDS == 4) begin : g_m4
            assign w_mix = w_ror3 ^ win_q[1];
        end else begin : g_m23
            assign w_mix = w_ror3;
        end
    endgenerate

    assign w_tmp       = w_mix ^ {w_mix[0], w_mix[WORD_W-1:1]};
    assign w_zbit      = Z_CONST[6'd61 - z_q];
    assign w_new       = ~win_q[0] ^ w_tmp ^ {{(WORD_W-1){1'b0}}, w_zbit} ^ WORD_W'(3);
    assign w_win_shift = {w_new, win_q[KEY_WORDS-1:1]};
    assign w_xfer      = (state_q == S_RUN) && rk_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (w_xfer && (rk_idx_q == LAST_IDX)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            win_q     <= '0;
            rk_data_q <= '0;
            rk_idx_q  <= '0;
            z_q       <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                win_q     <= key_in;
                rk_data_q <= key_in[WORD_W-1:0];
                rk_idx_q  <= '0;
                z_q       <= '0;
            end else if (w_xfer) begin
                win_q <= w_win_shift;
                z_q   <= (z_q == 6'd61) ? 6'd0 : z_q + 6'd1;
                // Output pair freezes on the final key so k[ROUNDS] never appears.
                if (rk_idx_q != LAST_IDX) begin
                    rk_idx_q  <= rk_idx_q + 1'b1;
                    rk_data_q <= win_q[1];
                end
            end
        end
    end

    assign busy     = (state_q == S_RUN);
    assign rk_valid = (state_q == S_RUN);
    assign done     = (state_q == S_FIN);
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;

`ifdef SIMON_KEY_STORE_EN
    logic [WORD_W-1:0] mem_q [ROUNDS];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < ROUNDS; a++) begin
                mem_q[a] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (w_xfer) begin
                mem_q[rk_idx_q] <= rk_data_q;
            end
            rd_data_q <= (rd_addr <= LAST_IDX) ? mem_q[rd_addr] : '0;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_key_schedule
// Brief    : Directed, table-driven bench for simon_key_schedule.
// Revision : 1.0
// ============================================================================
module tb_simon_key_schedule;

    localparam logic [255:0] KEY16   = 256'h1918_1110_0908_0100;
    localparam logic [255:0] OTHER16 = 256'hdead_beef_cafe_f00d;
    localparam logic [255:0] KEY64   =
        256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key_in;
    logic        busy, done, rk_valid, rk_ready;
    logic [15:0] rk_data;
    logic [4:0]  rk_idx;

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] gold [72];

    typedef struct {
        logic [4:0]  idx;
        logic [15:0] data;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

`ifdef SIMON_KEY_STORE_EN
    logic [4:0]   rd_addr;
    logic [15:0]  rd_data;
    logic         start64, busy64, done64, valid64, ready64;
    logic [255:0] key64_in;
    logic [6:0]   rd_addr64, idx64;
    logic [63:0]  rd_data64, data64;

    simon_key_schedule #(.WORD_W(64), .KEY_WORDS(4), .ROUNDS(72), .Z_SEQ(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .key_in(key64_in),
        .rd_addr(rd_addr64), .rd_data(rd_data64),
        .busy(busy64), .done(done64), .rk_valid(valid64), .rk_ready(ready64),
        .rk_data(data64), .rk_idx(idx64)
    );
`endif

    simon_key_schedule u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
`ifdef SIMON_KEY_STORE_EN
        .rd_addr(rd_addr), .rd_data(rd_data),
`endif
        .busy(busy), .done(done), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_data(rk_data), .rk_idx(rk_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic zbit(input int zs, input int j);
        logic [61:0] z;
        case (zs)
            0: z = 62'b11111010001001010110000111001101111101000100101011000011100110;
            1: z = 62'b10001110111110010011000010110101000111011111001001100001011010;
            2: z = 62'b10101111011100000011010010011000101000010001111110010110110011;
            3: z = 62'b11011011101011000110010111100000010010001010011100110100001111;
            default: z = 62'b11010001111001101011011000100000010111000011001010010011101111;
        endcase
        return z[61-j];
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n,
                                        input logic [63:0] mask);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    // Reference Simon key expansion, evaluated in software.
    task automatic build_gold(input logic [255:0] key, input int n, input int m,
                              input int t, input int zs);
        logic [63:0] mask, tmp;
        mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < 72; i++) gold[i] = '0;
        for (int i = 0; i < m; i++) gold[i] = 64'(key >> (i * n)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = ror(gold[i-1], 3, n, mask);
            if (m == 4) tmp = tmp ^ gold[i-3];
            tmp = tmp ^ ror(tmp, 1, n, mask);
            gold[i] = (~gold[i-m] ^ tmp ^ 64'(zbit(zs, (i - m) % 62)) ^ 64'd3) & mask;
        end
    endtask

    task automatic do_start(input logic [255:0] key);
        key_in = key[63:0];
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic drain_to_done(input string name);
        for (int c = 0; c < 40 && !done; c++) tick();
        chk(name, {63'd0, done}, 64'd1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{idx: 5'd0, data: 16'h0100};
        tbl[1] = '{idx: 5'd1, data: 16'h0908};
        tbl[2] = '{idx: 5'd2, data: 16'h1110};
        tbl[3] = '{idx: 5'd3, data: 16'h1918};
        tbl[4] = '{idx: 5'd4, data: 16'h71C3};

        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
`ifdef SIMON_KEY_STORE_EN
        rd_addr = '0; start64 = 1'b0; key64_in = '0; ready64 = 1'b0; rd_addr64 = '0;
`endif
        tick(); tick();
        chk("reset busy",  {63'd0, busy},     64'd0);
        chk("reset done",  {63'd0, done},     64'd0);
        chk("reset valid", {63'd0, rk_valid}, 64'd0);
        chk("reset idx",   {59'd0, rk_idx},   64'd0);
        chk("reset data",  {48'd0, rk_data},  64'd0);
        rst_n = 1'b1;
        tick();

        // Full schedule with ready held high.
        build_gold(KEY16, 16, 4, 32, 0);
        rk_ready = 1'b1;
        do_start(KEY16);
        for (int i = 0; i < 32; i++) begin
            if (i < 5) begin
                chk($sformatf("tbl data %0d", i), {48'd0, rk_data}, {48'd0, tbl[i].data});
                chk($sformatf("tbl idx %0d", i),  {59'd0, rk_idx},  {59'd0, tbl[i].idx});
            end else begin
                chk($sformatf("run data %0d", i), {48'd0, rk_data}, gold[i]);
                chk($sformatf("run idx %0d", i),  {59'd0, rk_idx},  64'(i));
            end
            chk($sformatf("run valid %0d", i), {63'd0, rk_valid}, 64'd1);
            chk($sformatf("run done %0d", i),  {63'd0, done},     64'd0);
            tick();
        end
        chk("fin done",  {63'd0, done},     64'd1);
        chk("fin busy",  {63'd0, busy},     64'd0);
        chk("fin valid", {63'd0, rk_valid}, 64'd0);
        tick();
        chk("idle done pulse", {63'd0, done},    64'd0);
        chk("idle data hold",  {48'd0, rk_data}, gold[31]);
`ifdef SIMON_KEY_STORE_EN
        rd_addr = 5'd4;
        tick();
        chk("store16 k4", {48'd0, rd_data}, 64'h71C3);
`endif

        // Back-pressure at rk_idx 4.
        do_start(KEY16);
        for (int i = 0; i < 4; i++) tick();
        chk("stall entry", {48'd0, rk_data}, 64'h71C3);
        rk_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall data %0d", c), {48'd0, rk_data}, 64'h71C3);
            chk($sformatf("stall idx %0d", c),  {59'd0, rk_idx},  64'd4);
            chk($sformatf("stall valid %0d", c), {63'd0, rk_valid}, 64'd1);
        end
        rk_ready = 1'b1;
        tick();
        chk("post stall idx",  {59'd0, rk_idx},  64'd5);
        chk("post stall data", {48'd0, rk_data}, gold[5]);
        drain_to_done("stall run done");

        // start with another key mid-run is ignored.
        do_start(KEY16);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("ign data %0d", i), {48'd0, rk_data}, gold[i]);
            chk($sformatf("ign idx %0d", i),  {59'd0, rk_idx},  64'(i));
            if (i == 10) begin
                start = 1'b1; key_in = OTHER16[63:0];
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("ign done", {63'd0, done}, 64'd1);
        tick();

        // Reset mid-run, with start asserted alongside it.
        do_start(KEY16);
        for (int i = 0; i < 7; i++) tick();
        chk("pre reset idx", {59'd0, rk_idx}, 64'd7);
        rst_n = 1'b0; start = 1'b1; key_in = KEY16[63:0];
        tick();
        chk("abort busy",  {63'd0, busy},     64'd0);
        chk("abort valid", {63'd0, rk_valid}, 64'd0);
        chk("abort idx",   {59'd0, rk_idx},   64'd0);
        chk("abort data",  {48'd0, rk_data},  64'd0);
        chk("abort done",  {63'd0, done},     64'd0);
        rst_n = 1'b1; start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("after abort done %0d", c), {63'd0, done}, 64'd0);
            chk($sformatf("after abort busy %0d", c), {63'd0, busy}, 64'd0);
        end
        do_start(KEY16);
        chk("restart data", {48'd0, rk_data}, 64'h0100);
        chk("restart idx",  {59'd0, rk_idx},  64'd0);
        drain_to_done("restart done");

`ifdef SIMON_KEY_STORE_EN
        // Wide configuration: 72 keys, z pointer wraps past 61.
        build_gold(KEY64, 64, 4, 72, 4);
        ready64 = 1'b1; key64_in = KEY64; start64 = 1'b1;
        tick();
        start64 = 1'b0;
        for (int i = 0; i < 72; i++) begin
            chk($sformatf("w64 data %0d", i), data64, gold[i]);
            chk($sformatf("w64 idx %0d", i),  {57'd0, idx64}, 64'(i));
            tick();
        end
        chk("w64 done", {63'd0, done64}, 64'd1);
        tick();
        rd_addr64 = 7'd4;
        tick();
        chk("store64 k4", rd_data64, gold[4]);
        rd_addr64 = 7'd71;
        tick();
        chk("store64 k71", rd_data64, gold[71]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simon_key_schedule.md
SIMON_KEY_SCHEDULE -- requirements
Module: simon_key_schedule

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning key word width n in bits (legal 16, 24, 32, 48, 64).
REQ-002 The block SHALL have parameter KEY_WORDS, default 4, meaning number of master key words m (legal 2, 3, 4).
REQ-003 The block SHALL have parameter ROUNDS, default 32, meaning number of round keys T (legal KEY_WORDS..72).
REQ-004 The block SHALL have parameter Z_SEQ, default 0, meaning the Simon constant sequence z0..z4 to use (legal 0..4).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: a synchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: a request to load key_in and begin a schedule.
REQ-008 The block SHALL have port key_in, input, KEY_WORDS*WORD_W bits: master key, with k[0] in bits [WORD_W-1:0] and k[j] at bits [j*WORD_W +: WORD_W].
REQ-009 The block SHALL have port busy, output, 1 bit: high while a schedule is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the last round key is accepted.
REQ-011 The block SHALL have port rk_valid, output, 1 bit: round key valid.
REQ-012 The block SHALL have port rk_ready, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port rk_data, output, WORD_W bits: round key k[rk_idx].
REQ-014 The block SHALL have port rk_idx, output, $clog2(ROUNDS) bits: index of rk_data.
REQ-015 The block SHALL have port rd_addr, input, $clog2(ROUNDS) bits: key-store read address (only when SIMON_KEY_STORE_EN is defined).
REQ-016 The block SHALL have port rd_data, output, WORD_W bits: key-store read data (only when SIMON_KEY_STORE_EN is defined).

Function
REQ-017 The block SHALL implement a state machine with states IDLE, RUN and FIN; busy SHALL be 1 exactly in RUN.
REQ-018 In IDLE, start=1 SHALL load a KEY_WORDS-word window with key_in, set rk_idx to 0, clear the z pointer, and enter RUN on the next cycle.
REQ-019 In RUN, rk_valid SHALL be 1, and rk_data SHALL equal the oldest window word, which is k[rk_idx].
REQ-020 A transfer SHALL occur when rk_valid and rk_ready are both 1, at most one key per cycle; with rk_ready held high the block SHALL deliver one key every cycle.
REQ-021 On each transfer the window SHALL shift by one word and append k[rk_idx+KEY_WORDS], and both rk_idx and the z pointer SHALL increment.
REQ-022 The new word SHALL be computed as: tmp = ROR3(k[i-1]); if KEY_WORDS==4, tmp ^= k[i-3]; tmp ^= ROR1(tmp); k[i] = ~k[i-m] ^ tmp ^ z[j] ^ 3.
REQ-023 All arithmetic in REQ-022 SHALL be modulo 2^WORD_W.
REQ-024 The z pointer j SHALL equal i-m modulo 62, wrapping from 61 to 0.
REQ-025 Bit j of the 62-bit z constant SHALL be element j of the standard Simon sequence; z0 = 11111010001001010110000111001101111101000100101011000011100110 read left to right.
REQ-026 While rk_valid=1 and rk_ready=0, rk_data and rk_idx SHALL hold stable.
REQ-027 A transfer with rk_idx==ROUNDS-1 SHALL move the block to FIN; in FIN rk_valid SHALL be 0 and done SHALL be 1 for one cycle, after which the block SHALL return to IDLE.
REQ-028 start SHALL be ignored in RUN and FIN.
REQ-029 Keys k[ROUNDS..] SHALL never be presented.
REQ-030 rk_valid SHALL be 0 in IDLE, and rk_data SHALL hold its last value there.

Reset
REQ-031 On a clk edge with rst_n=0 the block SHALL enter IDLE and drive busy=0, done=0, rk_valid=0, rk_idx=0, rk_data=0, rd_data=0, with window, z pointer and key store cleared to 0.
REQ-032 A reset in RUN SHALL abort the schedule without a done pulse.
REQ-033 When rst_n=0 and start=1 in the same cycle, reset SHALL win.

Configuration
REQ-034 When SIMON_KEY_STORE_EN is defined, every transferred key SHALL be written to a ROUNDS x WORD_W store at address rk_idx.
REQ-035 When SIMON_KEY_STORE_EN is defined, rd_data SHALL return store[rd_addr] one cycle after rd_addr is applied, entries written in the current schedule SHALL be valid, and the store SHALL be retained in IDLE until the next start.
REQ-036 When SIMON_KEY_STORE_EN is not defined, the store, rd_addr and rd_data SHALL not exist, and the block SHALL be streaming only.

Verification
REQ-037 The bench SHALL cover: defaults, key_in=0x1918_1110_0908_0100, rk_ready=1 -> rk_data 0x0100, 0x0908, 0x1110, 0x1918, 0x71C3 on consecutive cycles with rk_idx 0..4.
REQ-038 The bench SHALL cover: same run -> exactly 32 transfers, done a single pulse the cycle after rk_idx=31 is accepted, busy falling with it.
REQ-039 The bench SHALL cover: rk_ready low 3 cycles at rk_idx=4 -> rk_data held at 0x71C3, and the next key follows only after rk_ready rises.
REQ-040 The bench SHALL cover: start pulsed at rk_idx=10 with a different key -> ignored, and the key sequence matches the golden model.
REQ-041 The bench SHALL cover: rst_n=0 at rk_idx=7 -> next cycle busy=0, rk_valid=0, rk_idx=0, no done, and a fresh start reproduces 0x0100 first.
REQ-042 The bench SHALL cover: SIMON_KEY_STORE_EN defined with WORD_W=64, KEY_WORDS=4, ROUNDS=72, Z_SEQ=4 -> all 72 keys match the golden model, z wraps after 62, and rd_addr=4 returns the k[4] stream value one cycle later.
